// File: rtl/b_bus_mux_reg_if.sv
// b_bus_mux_reg_if: B-bus source/select/result bundle between control unit and bus mux
interface b_bus_mux_reg_if #(
    parameter int DATA_W    = 16,
    parameter int N_SRC     = 5,
    parameter int IDX_W     = $clog2(N_SRC),
    parameter int ERR_CNT_W = 8
);
    logic [N_SRC*DATA_W-1:0] src_data_in;
    logic [N_SRC-1:0]        sel;
    logic                    hold;
    logic                    err_clr;
    logic [DATA_W-1:0]       data_out;
    logic                    data_valid;
    logic [IDX_W-1:0]        src_id;
    logic                    sel_err;
    logic [ERR_CNT_W-1:0]    err_cnt;
    modport master (
        output src_data_in, sel, hold, err_clr,
        input  data_out, data_valid, src_id, sel_err, err_cnt
    );
    modport slave (
        input  src_data_in, sel, hold, err_clr,
        output data_out, data_valid, src_id, sel_err, err_cnt
    );
endinterface

// File: rtl/b_bus_mux_reg.sv
// b_bus_mux_reg: registered one-hot B-bus source mux with valid/tag, hold, idle value and illegal-select counter
module b_bus_mux_reg #(
    parameter int               DATA_W    = 16,
    parameter int               N_SRC     = 5,
    parameter int               IDX_W     = $clog2(N_SRC),
    parameter bit               HOLD_LAST = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_VAL = '0,
    parameter int               ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    b_bus_mux_reg_if.slave   bus
);
    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic                 w_none;
    logic                 w_onehot;
    logic                 w_multi;
    logic [IDX_W-1:0]     w_idx;
    logic [DATA_W-1:0]    w_word;
    logic [DATA_W-1:0]    r_data_out;
    logic                 r_data_valid;
    logic [IDX_W-1:0]     r_src_id;
    logic                 r_sel_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // asynchronous assertion, release delayed two edges so all state leaves reset together
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};

    assign w_rst_n  = r_rst_sync[1];
    assign w_none   = (bus.sel == '0);
    assign w_onehot = !w_none && ((bus.sel & (bus.sel - N_SRC'(1))) == '0);
    assign w_multi  = !w_none && !w_onehot;

    // binary index and data slice of the selected source; only meaningful when one-hot
    always_comb begin
        w_idx  = '0;
        w_word = '0;
        for (int i = 0; i < N_SRC; i++)
            if (bus.sel[i]) begin
                w_idx  = IDX_W'(i);
                w_word = bus.src_data_in[i*DATA_W +: DATA_W];
            end
    end

    // data path: one-hot loads the source, anything else idles without merging sources
    always_ff @(posedge clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_data_out   <= IDLE_VAL;
            r_data_valid <= 1'b0;
            r_src_id     <= '0;
        end else if (!bus.hold) begin
            r_data_out   <= w_onehot ? w_word : (HOLD_LAST ? r_data_out : IDLE_VAL);
            r_data_valid <= w_onehot;
            if (w_onehot) r_src_id <= w_idx;
        end

    // error path ignores hold; a multi-hot select in the same cycle as a clear wins
    always_ff @(posedge clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_sel_err <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_multi) begin
            r_sel_err <= 1'b1;
            r_err_cnt <= bus.err_clr ? ERR_CNT_W'(1) : (&r_err_cnt ? r_err_cnt : r_err_cnt + 1'b1);
        end else if (bus.err_clr) begin
            r_sel_err <= 1'b0;
            r_err_cnt <= '0;
        end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.src_id     = r_src_id;
    assign bus.sel_err    = r_sel_err;
    assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_b_bus_mux_reg.sv
// tb_b_bus_mux_reg: directed vectors against three configurations of b_bus_mux_reg
module tb_b_bus_mux_reg;
    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [4:0][15:0] src;
    logic [4:0]      sel;
    logic            hold;
    logic            err_clr;
    int              n_vec = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    b_bus_mux_reg_if #(.DATA_W(16), .N_SRC(5), .ERR_CNT_W(8)) b0 ();
    b_bus_mux_reg_if #(.DATA_W(16), .N_SRC(5), .ERR_CNT_W(8)) b1 ();
    b_bus_mux_reg_if #(.DATA_W(16), .N_SRC(5), .ERR_CNT_W(2)) b2 ();

    assign b0.src_data_in = src;
    assign b0.sel         = sel;
    assign b0.hold        = hold;
    assign b0.err_clr     = err_clr;
    assign b1.src_data_in = src;
    assign b1.sel         = sel;
    assign b1.hold        = hold;
    assign b1.err_clr     = err_clr;
    assign b2.src_data_in = src;
    assign b2.sel         = sel;
    assign b2.hold        = hold;
    assign b2.err_clr     = err_clr;

    b_bus_mux_reg #(.DATA_W(16), .N_SRC(5), .HOLD_LAST(1'b0), .IDLE_VAL(16'h0000), .ERR_CNT_W(8))
        dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    b_bus_mux_reg #(.DATA_W(16), .N_SRC(5), .HOLD_LAST(1'b1), .IDLE_VAL(16'h0000), .ERR_CNT_W(8))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    b_bus_mux_reg #(.DATA_W(16), .N_SRC(5), .HOLD_LAST(1'b0), .IDLE_VAL(16'h0000), .ERR_CNT_W(2))
        dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        src = '0; sel = '0; hold = 1'b0; err_clr = 1'b0;
        #1 reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        // dirty all state, then reset mid-run
        sel = 5'b00011; src[0] = 16'h7777;
        step();
        sel = 5'b00100; src[2] = 16'h9999;
        step();
        chk("pre_rst_data", 32'(b0.data_out), 32'h9999);
        chk("pre_rst_err", 32'(b0.err_cnt), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_data", 32'(b0.data_out), 32'h0);
        chk("rst_async_valid", 32'(b0.data_valid), 32'h0);
        chk("rst_async_id", 32'(b0.src_id), 32'h0);
        chk("rst_async_err", 32'(b0.sel_err), 32'h0);
        chk("rst_async_cnt", 32'(b0.err_cnt), 32'h0);
        step();
        chk("rst_held_data", 32'(b1.data_out), 32'h0);
        reset_n = 1'b1;
        sel = '0;
        repeat (3) step();
        // test 1: one-hot sweep
        src = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 5; i++) begin
            sel = 5'(1 << i);
            step();
            chk("sweep_data", 32'(b0.data_out), 32'(16'h1111 * (i + 1)));
            chk("sweep_valid", 32'(b0.data_valid), 32'h1);
            chk("sweep_id", 32'(b0.src_id), 32'(i));
        end
        // test 2: idle select in both modes
        src[2] = 16'hABCD; sel = 5'b00100;
        step();
        sel = 5'b00000;
        step();
        chk("idle0_data", 32'(b0.data_out), 32'h0000);
        chk("idle0_valid", 32'(b0.data_valid), 32'h0);
        chk("idle0_id", 32'(b0.src_id), 32'd2);
        chk("idle1_data", 32'(b1.data_out), 32'hABCD);
        chk("idle1_valid", 32'(b1.data_valid), 32'h0);
        // test 3: hold
        src[1] = 16'h00F0; sel = 5'b00010;
        step();
        hold = 1'b1; sel = 5'b10000; src[4] = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_data", 32'(b0.data_out), 32'h00F0);
            chk("hold_id", 32'(b0.src_id), 32'd1);
            chk("hold_valid", 32'(b0.data_valid), 32'h1);
        end
        hold = 1'b0;
        step();
        chk("unhold_data", 32'(b0.data_out), 32'hBEEF);
        chk("unhold_id", 32'(b0.src_id), 32'd4);
        // test 4: illegal select, hold on the middle cycle
        src[0] = 16'h1111; src[3] = 16'h4444; sel = 5'b01001;
        step();
        chk("ill1_valid", 32'(b0.data_valid), 32'h0);
        chk("ill1_err", 32'(b0.sel_err), 32'h1);
        chk("ill1_data0", 32'(b0.data_out), 32'h0000);
        chk("ill1_data1", 32'(b1.data_out), 32'hBEEF);
        hold = 1'b1;
        step();
        chk("ill2_err", 32'(b0.sel_err), 32'h1);
        chk("ill2_cnt", 32'(b0.err_cnt), 32'd2);
        hold = 1'b0;
        step();
        chk("ill3_valid", 32'(b0.data_valid), 32'h0);
        chk("ill3_cnt", 32'(b0.err_cnt), 32'd3);
        chk("ill3_data0", 32'(b0.data_out), 32'h0000);
        chk("ill3_data1", 32'(b1.data_out), 32'hBEEF);
        // test 5: saturation and clear on the 2-bit counter
        sel = 5'b00000; err_clr = 1'b1;
        step();
        chk("clr_cnt0", 32'(b0.err_cnt), 32'd0);
        err_clr = 1'b0; sel = 5'b11000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat_cnt", 32'(b2.err_cnt), 32'(i < 3 ? i + 1 : 3));
            chk("wide_cnt", 32'(b0.err_cnt), 32'(i + 1));
        end
        err_clr = 1'b1; sel = 5'b00001;
        step();
        chk("clr_err", 32'(b2.sel_err), 32'h0);
        chk("clr_cnt", 32'(b2.err_cnt), 32'd0);
        sel = 5'b00011;
        step();
        chk("clr_multi_err", 32'(b2.sel_err), 32'h1);
        chk("clr_multi_cnt", 32'(b2.err_cnt), 32'd1);
        chk("clr_multi_cnt8", 32'(b0.err_cnt), 32'd1);
        err_clr = 1'b0;
        // test 6: back-to-back switching with sources changing every cycle
        for (int i = 0; i < 8; i++) begin
            src[0] = 16'h6000 + 16'(i);
            src[4] = 16'h6A00 + 16'(i);
            sel = (i % 2 == 0) ? 5'b00001 : 5'b10000;
            step();
            chk("b2b_data", 32'(b0.data_out), 32'((i % 2 == 0) ? 16'h6000 + 16'(i) : 16'h6A00 + 16'(i)));
            chk("b2b_id", 32'(b0.src_id), 32'((i % 2 == 0) ? 0 : 4));
            chk("b2b_valid", 32'(b0.data_valid), 32'h1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/b_bus_mux_reg.md
Name: b_bus_mux_reg

Overview:
Parametrised, registered B-bus source multiplexer for the datapath. It takes N_SRC register outputs (e.g. MAR, PC, MDR, GP, IR) and a one-hot select from the control unit, and drives one registered bus word per clock.
It adds behaviour beyond a plain combinational bus select:
- output valid flag and source-index tag;
- hold/stall input;
- configurable idle value;
- sticky illegal-select detection with a saturating error counter.

It feeds the ALU B-operand and the register write-back path.

Parameters:
- DATA_W, 16: bus word width in bits.
- N_SRC, 5: number of bus sources; must be ≥ 2.
- IDX_W, $clog2(N_SRC): width of src_id.
- HOLD_LAST, 0: 1 = keep the last driven word when idle; 0 = load IDLE_VAL when idle.
- IDLE_VAL, 0: DATA_W-bit word loaded on idle or illegal select when HOLD_LAST=0.
- ERR_CNT_W, 8: width of the illegal-select counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- src_data_in, input, N_SRC*DATA_W: source i occupies bits [i*DATA_W +: DATA_W].
- sel, input, N_SRC: one-hot source select; bit i selects source i.
- hold, input, 1: freezes the data-path registers.
- err_clr, input, 1: clears sel_err and err_cnt.
- data_out, output, DATA_W: registered bus word.
- data_valid, output, 1: data_out was loaded from a legal one-hot select.
- src_id, output, IDX_W: binary index of the source that produced data_out.
- sel_err, output, 1: sticky flag; a multi-hot select has been seen.
- err_cnt, output, ERR_CNT_W: saturating count of cycles with a multi-hot select.

Behaviour:

Reset:
- reset_n low asynchronously forces data_out=IDLE_VAL, data_valid=0, src_id=0, sel_err=0, err_cnt=0.
- Release is synchronous to clk (two-flop synchroniser on deassertion inside the block).
- Reset mid-transfer discards the in-flight word.

Select classification (combinational, per cycle):
- ONEHOT: exactly one bit of sel set.
- NONE: sel == 0.
- MULTI: two or more bits set.

Data path:
- Latency is exactly 1 cycle: the sel/src_data_in sampled at edge k appear on data_out after edge k.
- hold=0, ONEHOT bit i: data_out ← slice i; data_valid ← 1; src_id ← i.
- hold=0, NONE:
  - data_valid ← 0; src_id unchanged.
  - data_out ← data_out if HOLD_LAST=1, else IDLE_VAL.
- hold=0, MULTI:
  - data_valid ← 0; src_id unchanged.
  - data_out as in NONE (no OR/priority merge of sources, ever).
- hold=1: data_out, data_valid and src_id keep their values regardless of sel.

Error path (independent of hold):
- MULTI sets sel_err ← 1.
- MULTI increments err_cnt by 1, saturating at 2^ERR_CNT_W − 1 with no wrap.
- err_clr=1 with no MULTI in the same cycle: sel_err ← 0, err_cnt ← 0.
- err_clr=1 with MULTI in the same cycle: the error wins, giving sel_err=1, err_cnt=1.

Other rules:
- No tri-state anywhere; the block is purely internal registered logic.
- Source data changing while its sel bit is held has new data captured each cycle (no latching of the first value).

Test Plan:
1. Reset/one-hot sweep (DATA_W=16, N_SRC=5, HOLD_LAST=0). Assert reset_n=0 mid-run, then release and drive sources 0..4 = 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555 with sel=00001, 00010, 00100, 01000, 10000 on consecutive cycles.
   Required: during reset all outputs are zero. After release, data_out = 1111, 2222, 3333, 4444, 5555, each one cycle after its sel, with data_valid=1 and src_id = 0..4.
2. Idle select, both modes. Drive sel=00100 (source 2 = 16'hABCD), then sel=00000.
   Required with HOLD_LAST=0: data_out=16'h0000, data_valid=0, src_id=2.
   Required with HOLD_LAST=1: data_out stays 16'hABCD, data_valid=0.
3. Hold. Drive sel=00010 (source 1 = 16'h00F0), then hold=1 for 3 cycles while sel=10000 and source 4 = 16'hBEEF.
   Required: data_out stays 16'h00F0, src_id=1, data_valid=1 for all 3 cycles. On the first cycle after hold drops, data_out=16'hBEEF and src_id=4.
4. Illegal select. Drive sel=01001 for 3 cycles, with hold=1 on the second cycle.
   Required: data_valid=0 on the two non-hold cycles; sel_err=1 from the first cycle; err_cnt=3; data_out never equals the OR of the two sources.
5. Saturation and clear (ERR_CNT_W=2). Hold sel=11000 for 5 cycles, then apply err_clr with sel legal, then apply err_clr together with sel=00011.
   Required: err_cnt = 1, 2, 3, 3, 3. After the legal clear: sel_err=0, err_cnt=0. After the simultaneous clear: sel_err=1, err_cnt=1.
6. Back-to-back source switching. Drive sel alternating 00001/10000 every cycle with sources changing every cycle.
   Required: every data_out equals the selected source from the prior edge; no bubble and no stale word.
